// File: rtl/kmeans_fsl_sequencer.sv
// kmeans_fsl_sequencer
//
// Purpose:
//   Takes one k-means job over an FSL link and drives the distance core.
//   1. A header word (Control=1) carries the cluster count k in bits [5:0]
//      and the dimension dim in bits [25:16].
//   2. The job then loads dim point words into the point memory (mem_a).
//   3. It then loads k*dim centroid words into the centroid memory (mem_b).
//      Each centroid starts at a stride of MAX_DIM, and the element index
//      advances fastest.
//   4. The core runs through the start/stb/ack handshake.
//   5. The nearest-centroid result is sent back out on the FSL master side.
//   A malformed header, or a header word that arrives mid-load, produces a
//   single error word (all ones, Control=1) instead of a result.
//
// Ports:
//   FSL_Clk, FSL_Rst             clock, asynchronous active-low reset
//   FSL_S_Data/Control/Exists    inbound FSL word, header flag, word available
//   FSL_S_Read                   consume the current inbound word
//   FSL_M_Data/Control/Write     outbound word, error flag, write strobe
//   FSL_M_Full                   outbound FIFO full
//   mem_a_*                      point memory write port (9-bit address)
//   mem_b_*                      centroid memory write port (14-bit address)
//   k, dim                       job configuration to the distance core
//   start, ack                   core run request, result acknowledge
//   stb, result                  core result valid, nearest-centroid result
module kmeans_fsl_sequencer #(
  parameter int DATA_W  = 32,
  parameter int MAX_K   = 32,
  parameter int MAX_DIM = 512
) (
  input  logic              FSL_Clk,
  input  logic              FSL_Rst,
  input  logic [DATA_W-1:0] FSL_S_Data,
  input  logic              FSL_S_Control,
  input  logic              FSL_S_Exists,
  output logic              FSL_S_Read,
  output logic [DATA_W-1:0] FSL_M_Data,
  output logic              FSL_M_Control,
  output logic              FSL_M_Write,
  input  logic              FSL_M_Full,
  output logic [8:0]        mem_a_address,
  output logic [DATA_W-1:0] mem_a_input_data,
  output logic              mem_a_write_enable,
  output logic [13:0]       mem_b_address,
  output logic [DATA_W-1:0] mem_b_input_data,
  output logic              mem_b_write_enable,
  output logic [5:0]        k,
  output logic [9:0]        dim,
  output logic              start,
  output logic              ack,
  input  logic              stb,
  input  logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, RUN, ACK, SEND, ERR
  } state_t;

  state_t      state;
  logic [9:0]  elem_cnt;
  logic [5:0]  cent_cnt;
  logic [13:0] cent_base;

  logic        in_load;
  logic        consume;
  logic [5:0]  hdr_k;
  logic [9:0]  hdr_dim;
  logic        hdr_bad;
  logic        last_elem;
  logic        last_cent;

  assign in_load = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);

  // The read strobe is gated by reset so that every output reads 0 while
  // reset is asserted, even though the state register already sits in IDLE.
  assign FSL_S_Read = FSL_Rst && FSL_S_Exists && in_load;
  assign consume    = FSL_S_Read;

  assign hdr_k   = FSL_S_Data[5:0];
  assign hdr_dim = FSL_S_Data[25:16];
  assign hdr_bad = (hdr_k == 6'd0) || (int'(hdr_k) > MAX_K) ||
                   (hdr_dim == 10'd0) || (int'(hdr_dim) > MAX_DIM);

  assign last_elem = (elem_cnt == dim - 10'd1);
  assign last_cent = (cent_cnt == k - 6'd1);

  // The write strobe is combinational on FSL_M_Full. This way the word
  // leaves in the very cycle the FIFO has room, and the strobe is never
  // asserted while the FIFO is full.
  assign FSL_M_Write   = FSL_Rst && !FSL_M_Full && ((state == SEND) || (state == ERR));
  assign FSL_M_Control = FSL_Rst && (state == ERR);

  // Main sequencer.
  // - Memory write strobes default low, so each consumed data word gives
  //   exactly one registered write pulse.
  // - The centroid base advances by MAX_DIM per centroid, which avoids a
  //   multiplier on the mem_b address path.
  // - start is raised one cycle after entering RUN, which lines it up with
  //   the cycle after the last centroid write.
  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      state              <= IDLE;
      elem_cnt           <= '0;
      cent_cnt           <= '0;
      cent_base          <= '0;
      k                  <= '0;
      dim                <= '0;
      start              <= 1'b0;
      ack                <= 1'b0;
      FSL_M_Data         <= '0;
      mem_a_address      <= '0;
      mem_a_input_data   <= '0;
      mem_a_write_enable <= 1'b0;
      mem_b_address      <= '0;
      mem_b_input_data   <= '0;
      mem_b_write_enable <= 1'b0;
    end else begin
      mem_a_write_enable <= 1'b0;
      mem_b_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (consume && FSL_S_Control) begin
            if (hdr_bad) begin
              FSL_M_Data <= '1;
              state      <= ERR;
            end else begin
              k         <= hdr_k;
              dim       <= hdr_dim;
              elem_cnt  <= '0;
              cent_cnt  <= '0;
              cent_base <= '0;
              state     <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (consume) begin
            if (FSL_S_Control) begin
              FSL_M_Data <= '1;
              state      <= ERR;
            end else begin
              mem_a_write_enable <= 1'b1;
              mem_a_address      <= elem_cnt[8:0];
              mem_a_input_data   <= FSL_S_Data;
              if (last_elem) begin
                elem_cnt <= '0;
                state    <= LOAD_B;
              end else begin
                elem_cnt <= elem_cnt + 10'd1;
              end
            end
          end
        end
        LOAD_B: begin
          if (consume) begin
            if (FSL_S_Control) begin
              FSL_M_Data <= '1;
              state      <= ERR;
            end else begin
              mem_b_write_enable <= 1'b1;
              mem_b_address      <= cent_base + 14'(elem_cnt);
              mem_b_input_data   <= FSL_S_Data;
              if (last_elem) begin
                elem_cnt <= '0;
                if (last_cent) begin
                  state <= RUN;
                end else begin
                  cent_cnt  <= cent_cnt + 6'd1;
                  cent_base <= cent_base + 14'(MAX_DIM);
                end
              end else begin
                elem_cnt <= elem_cnt + 10'd1;
              end
            end
          end
        end
        RUN: begin
          if (!start) begin
            start <= 1'b1;
          end else if (stb) begin
            start      <= 1'b0;
            ack        <= 1'b1;
            FSL_M_Data <= result;
            state      <= ACK;
          end
        end
        ACK: begin
          ack   <= 1'b0;
          state <= SEND;
        end
        SEND, ERR: begin
          if (!FSL_M_Full) begin
            FSL_M_Data <= '0;
            k          <= '0;
            dim        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_fsl_sequencer.sv
// tb_kmeans_fsl_sequencer
//
// Purpose:
//   Directed bench for kmeans_fsl_sequencer.
//   - Drives FSL words and models the distance core.
//   - Mirrors every memory write into local arrays.
//   - Compares against hand-computed expectations for the reference job
//     (k=3, dim=8), for bad headers, for a mid-load abort, for output
//     back-pressure and for reset in LOAD_B and RUN.
//
// Ports: none (top-level bench).
module tb_kmeans_fsl_sequencer;

  logic        FSL_Clk;
  logic        FSL_Rst;
  logic [31:0] FSL_S_Data;
  logic        FSL_S_Control;
  logic        FSL_S_Exists;
  logic        FSL_S_Read;
  logic [31:0] FSL_M_Data;
  logic        FSL_M_Control;
  logic        FSL_M_Write;
  logic        FSL_M_Full;
  logic [8:0]  mem_a_address;
  logic [31:0] mem_a_input_data;
  logic        mem_a_write_enable;
  logic [13:0] mem_b_address;
  logic [31:0] mem_b_input_data;
  logic        mem_b_write_enable;
  logic [5:0]  k;
  logic [9:0]  dim;
  logic        start;
  logic        ack;
  logic        stb;
  logic [31:0] result;

  int checks;
  int failures;

  int a_writes, b_writes, start_seen, ack_pulses, ack_start_overlap;
  int out_words, full_violation;
  logic [31:0] last_out_data;
  logic        last_out_ctrl;
  logic [31:0] mem_a_m [0:511];
  logic [31:0] mem_b_m [0:16383];
  logic [31:0] core_result;
  int          core_wait;
  int          cent_first [0:2];

  kmeans_fsl_sequencer dut (
    .FSL_Clk            (FSL_Clk),
    .FSL_Rst            (FSL_Rst),
    .FSL_S_Data         (FSL_S_Data),
    .FSL_S_Control      (FSL_S_Control),
    .FSL_S_Exists       (FSL_S_Exists),
    .FSL_S_Read         (FSL_S_Read),
    .FSL_M_Data         (FSL_M_Data),
    .FSL_M_Control      (FSL_M_Control),
    .FSL_M_Write        (FSL_M_Write),
    .FSL_M_Full         (FSL_M_Full),
    .mem_a_address      (mem_a_address),
    .mem_a_input_data   (mem_a_input_data),
    .mem_a_write_enable (mem_a_write_enable),
    .mem_b_address      (mem_b_address),
    .mem_b_input_data   (mem_b_input_data),
    .mem_b_write_enable (mem_b_write_enable),
    .k                  (k),
    .dim                (dim),
    .start              (start),
    .ack                (ack),
    .stb                (stb),
    .result             (result)
  );

  initial FSL_Clk = 1'b0;
  always #5 FSL_Clk = ~FSL_Clk;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Observes registered outputs at the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge FSL_Clk);
      if (mem_a_write_enable) begin
        a_writes++;
        mem_a_m[mem_a_address] = mem_a_input_data;
      end
      if (mem_b_write_enable) begin
        b_writes++;
        mem_b_m[mem_b_address] = mem_b_input_data;
      end
      if (start) start_seen++;
      if (ack) begin
        ack_pulses++;
        if (start) ack_start_overlap++;
      end
      if (FSL_M_Write) begin
        out_words++;
        last_out_data = FSL_M_Data;
        last_out_ctrl = FSL_M_Control;
        if (FSL_M_Full) full_violation++;
      end
    end
  end

  // Core model: answers three cycles after it first sees start, for one cycle.
  initial begin
    core_wait = 0;
    forever begin
      @(posedge FSL_Clk);
      #1;
      stb = 1'b0;
      if (start) begin
        core_wait++;
        if (core_wait == 3) begin
          stb       = 1'b1;
          result    = core_result;
          core_wait = 0;
        end
      end else begin
        core_wait = 0;
      end
    end
  end

  task automatic clearCounts();
    a_writes = 0; b_writes = 0; start_seen = 0; ack_pulses = 0;
    ack_start_overlap = 0; out_words = 0; full_violation = 0;
    last_out_data = '0; last_out_ctrl = 1'b0;
    for (int i = 0; i < 512; i++) mem_a_m[i] = '0;
    for (int i = 0; i < 16384; i++) mem_b_m[i] = '0;
  endtask

  // Offers one word and waits (bounded) for it to be consumed. With gap set,
  // an idle cycle with Exists low follows each word.
  task automatic applyStimulus(input logic [31:0] data, input logic ctrl, input bit gap);
    bit done;
    done = 1'b0;
    FSL_S_Data    = data;
    FSL_S_Control = ctrl;
    FSL_S_Exists  = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge FSL_Clk);
      if (FSL_S_Read) done = 1'b1;
      @(posedge FSL_Clk);
      #1;
    end
    FSL_S_Exists = 1'b0;
    if (!done) checkOutput("consume_timeout", 64'(done), 64'd1);
    if (gap) begin
      @(posedge FSL_Clk);
      #1;
    end
  endtask

  task automatic sendPoints(input int n, input bit gap);
    for (int i = 0; i < n; i++) applyStimulus(32'(i + 1), 1'b0, gap);
  endtask

  task automatic sendCentroids(input int n, input bit gap);
    for (int w = 0; w < n; w++) applyStimulus(32'(cent_first[w / 8] + (w % 8)), 1'b0, gap);
  endtask

  task automatic waitOut(input int n, input int budget);
    for (int i = 0; i < budget && out_words < n; i++) begin
      @(posedge FSL_Clk);
      #1;
    end
    checkOutput("out_count", 64'(out_words), 64'(n));
  endtask

  task automatic runJob(input bit gap, input logic [31:0] res);
    clearCounts();
    core_result = res;
    applyStimulus(32'h0008_0003, 1'b1, gap);
    checkOutput("hdr_k", 64'(k), 64'd3);
    checkOutput("hdr_dim", 64'(dim), 64'd8);
    sendPoints(8, gap);
    sendCentroids(24, gap);
    waitOut(1, 300);
  endtask

  task automatic verifyJob(input logic [31:0] res);
    checkOutput("a_writes", 64'(a_writes), 64'd8);
    checkOutput("b_writes", 64'(b_writes), 64'd24);
    for (int i = 0; i < 8; i++) checkOutput("mem_a", 64'(mem_a_m[i]), 64'(i + 1));
    for (int c = 0; c < 3; c++)
      for (int d = 0; d < 8; d++)
        checkOutput("mem_b", 64'(mem_b_m[c * 512 + d]), 64'(cent_first[c] + d));
    checkOutput("start_cycles", 64'(start_seen), 64'd3);
    checkOutput("ack_pulses", 64'(ack_pulses), 64'd1);
    checkOutput("ack_start_overlap", 64'(ack_start_overlap), 64'd0);
    checkOutput("result_data", 64'(last_out_data), 64'(res));
    checkOutput("result_ctrl", 64'(last_out_ctrl), 64'd0);
    checkOutput("k_cleared", 64'(k), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    logic any;
    any = |{FSL_S_Read, FSL_M_Data, FSL_M_Control, FSL_M_Write, mem_a_address,
            mem_a_input_data, mem_a_write_enable, mem_b_address, mem_b_input_data,
            mem_b_write_enable, k, dim, start, ack};
    checkOutput(tag, 64'(any), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    cent_first[0] = 4; cent_first[1] = 2; cent_first[2] = 3;
    FSL_Rst = 1'b0; FSL_S_Data = '0; FSL_S_Control = 1'b0; FSL_S_Exists = 1'b1;
    FSL_M_Full = 1'b0; stb = 1'b0; result = '0; core_result = '0;
    clearCounts();

    // Reset state, with Exists high to show the read strobe is held off.
    repeat (2) @(posedge FSL_Clk);
    #1;
    checkAllZero("reset_outputs");
    FSL_S_Exists = 1'b0;
    FSL_Rst = 1'b1;
    @(posedge FSL_Clk);
    #1;

    // Reference job, then the same job with Exists toggling.
    $display("[TB] reference job");
    runJob(1'b0, 32'd1);
    verifyJob(32'd1);
    $display("[TB] stalled job");
    runJob(1'b1, 32'd1);
    verifyJob(32'd1);
    checkOutput("total_writes", 64'(a_writes + b_writes), 64'd32);

    // Bad headers: dim=0, then k=33.
    $display("[TB] bad headers");
    clearCounts();
    applyStimulus(32'h0000_0003, 1'b1, 1'b0);
    waitOut(1, 50);
    checkOutput("err_dim0_data", 64'(last_out_data), 64'hFFFF_FFFF);
    checkOutput("err_dim0_ctrl", 64'(last_out_ctrl), 64'd1);
    applyStimulus(32'h0008_0021, 1'b1, 1'b0);
    waitOut(2, 50);
    checkOutput("err_k33_data", 64'(last_out_data), 64'hFFFF_FFFF);
    checkOutput("err_k33_ctrl", 64'(last_out_ctrl), 64'd1);
    checkOutput("err_writes", 64'(a_writes + b_writes), 64'd0);
    checkOutput("err_start", 64'(start_seen), 64'd0);

    // Header word arriving after three point words aborts the job.
    $display("[TB] abort in LOAD_A");
    clearCounts();
    applyStimulus(32'h0008_0003, 1'b1, 1'b0);
    sendPoints(3, 1'b0);
    applyStimulus(32'h0008_0003, 1'b1, 1'b0);
    waitOut(1, 50);
    checkOutput("abort_a_writes", 64'(a_writes), 64'd3);
    checkOutput("abort_b_writes", 64'(b_writes), 64'd0);
    checkOutput("abort_data", 64'(last_out_data), 64'hFFFF_FFFF);
    checkOutput("abort_ctrl", 64'(last_out_ctrl), 64'd1);
    checkOutput("abort_idle_dim", 64'(dim), 64'd0);

    // Strobe from the core while idle is ignored.
    @(negedge FSL_Clk);
    stb = 1'b1;
    result = 32'd99;
    repeat (5) @(posedge FSL_Clk);
    #1;
    checkOutput("stray_stb_ack", 64'(ack_pulses), 64'd0);
    checkOutput("stray_stb_out", 64'(out_words), 64'd1);

    // Output back-pressure: Full held for 10 cycles once SEND is reached.
    $display("[TB] back-pressure");
    clearCounts();
    core_result = 32'd5;
    FSL_M_Full = 1'b1;
    applyStimulus(32'h0008_0003, 1'b1, 1'b0);
    sendPoints(8, 1'b0);
    sendCentroids(24, 1'b0);
    for (int i = 0; i < 200 && ack_pulses == 0; i++) begin
      @(posedge FSL_Clk);
      #1;
    end
    checkOutput("bp_ack_seen", 64'(ack_pulses), 64'd1);
    repeat (10) @(posedge FSL_Clk);
    #1;
    checkOutput("bp_no_write", 64'(out_words), 64'd0);
    FSL_M_Full = 1'b0;
    @(negedge FSL_Clk);
    #1;
    checkOutput("bp_first_cycle", 64'(out_words), 64'd1);
    checkOutput("bp_data", 64'(last_out_data), 64'd5);
    checkOutput("bp_violation", 64'(full_violation), 64'd0);

    // Reset in the middle of LOAD_B.
    $display("[TB] reset in LOAD_B");
    @(posedge FSL_Clk);
    #1;
    clearCounts();
    applyStimulus(32'h0008_0003, 1'b1, 1'b0);
    sendPoints(8, 1'b0);
    sendCentroids(5, 1'b0);
    #2;
    FSL_Rst = 1'b0;
    FSL_S_Exists = 1'b1;
    #1;
    checkAllZero("rst_loadb_outputs");
    @(posedge FSL_Clk);
    #1;
    FSL_S_Exists = 1'b0;
    FSL_Rst = 1'b1;
    runJob(1'b0, 32'd7);
    verifyJob(32'd7);

    // Reset while the core is running.
    $display("[TB] reset in RUN");
    clearCounts();
    core_result = 32'd3;
    applyStimulus(32'h0008_0003, 1'b1, 1'b0);
    sendPoints(8, 1'b0);
    sendCentroids(24, 1'b0);
    for (int i = 0; i < 50 && !start; i++) begin
      @(posedge FSL_Clk);
      #1;
    end
    checkOutput("run_start_high", 64'(start), 64'd1);
    #2;
    FSL_Rst = 1'b0;
    #1;
    checkOutput("rst_run_start", 64'(start), 64'd0);
    checkAllZero("rst_run_outputs");
    @(posedge FSL_Clk);
    #1;
    FSL_Rst = 1'b1;
    runJob(1'b0, 32'd9);
    verifyJob(32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kmeans_fsl_sequencer.md
KMEANS_FSL_SEQUENCER -- requirements
Module: kmeans_fsl_sequencer

Interface
REQ-001 Parameter: DATA_W, 32, width of FSL words, memory data and result.
REQ-002 Parameter: MAX_K, 32, largest legal cluster count.
REQ-003 Parameter: MAX_DIM, 512, largest legal dimension and mem_b per-centroid stride.
REQ-004 Port: FSL_Clk  in  1  sole clock, all state on rising edge.
REQ-005 Port: FSL_Rst  in  1  reset, asynchronous and active-low.
REQ-006 Port: FSL_S_Data / FSL_S_Control / FSL_S_Exists  in  32/1/1  inbound FSL word, header flag, word available.
REQ-007 Port: FSL_S_Read  out  1  consume the current inbound word.
REQ-008 Port: FSL_M_Data / FSL_M_Control / FSL_M_Write  out  32/1/1  outbound word, error flag, write strobe.
REQ-009 Port: FSL_M_Full  in  1  outbound FIFO full.
REQ-010 Port: mem_a_address / mem_a_input_data / mem_a_write_enable  out  9/32/1  point-memory write port.
REQ-011 Port: mem_b_address / mem_b_input_data / mem_b_write_enable  out  14/32/1  centroid-memory write port.
REQ-012 Port: k / dim  out  6/10  job configuration to distance core, held stable from header until IDLE.
REQ-013 Port: start / ack  out  1/1  core run request, result acknowledge.
REQ-014 Port: stb / result  in  1/32  core result valid, nearest-centroid result.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_A, LOAD_B, RUN, ACK, SEND, ERR.
REQ-016 FSL_S_Read SHALL equal FSL_S_Exists in IDLE, LOAD_A, LOAD_B, else 0; a word is consumed when both are 1.
REQ-017 IDLE: consumed word with Control=1 is a header: k=Data[5:0], dim=Data[25:16]; Control=0 words in IDLE SHALL be discarded.
REQ-018 Header with k=0, k>MAX_K, dim=0 or dim>MAX_DIM SHALL go to ERR; else LOAD_A, word counters cleared.
REQ-019 LOAD_A: word i (0..dim-1) SHALL be written to mem_a address i; after word dim-1 go to LOAD_B.
REQ-020 LOAD_B: word for centroid c, element d SHALL be written to mem_b address c*MAX_DIM+d, d fastest; after c=k-1,d=dim-1 go to RUN.
REQ-021 Memory writes SHALL be registered: address/data/write_enable valid the cycle after consumption, write_enable high exactly one cycle per word.
REQ-022 Control=1 word consumed in LOAD_A/LOAD_B SHALL abort the job to ERR; no write for that word.
REQ-023 RUN: start SHALL be 1 from the cycle after the last memory write until the cycle after stb is sampled high.
REQ-024 On stb=1 in RUN: latch result, go to ACK; ACK SHALL drive ack=1 and start=0 for exactly one cycle, then SEND.
REQ-025 SEND: FSL_M_Write=1, FSL_M_Data=latched result, FSL_M_Control=0 in each cycle with FSL_M_Full=0; first such cycle completes the send, then IDLE.
REQ-026 ERR: write 32'hFFFF_FFFF with FSL_M_Control=1 under the same Full rule, then IDLE.
REQ-027 FSL_M_Write SHALL never be 1 while FSL_M_Full=1; FSL_S_Exists=0 SHALL stall loading without losing count.
REQ-028 stb outside RUN SHALL be ignored.

Reset
REQ-029 FSL_Rst=0 SHALL immediately force IDLE and all outputs to 0 (k, dim, addresses, data, strobes, start, ack), including mid-load or mid-run.
REQ-030 After reset release, memory contents written before reset SHALL not be relied upon; a new header is required.

Verification
REQ-031 Header k=3,dim=8; point 1..8; centroids 4..11, 2..9, 3..10; core model returns 1 -> mem_a 0..7=1..8, mem_b 0..7,512..519,1024..1031 loaded, start high, one ack pulse, FSL_M_Data=1, Control=0.
REQ-032 Same job with FSL_S_Exists toggling every other cycle -> identical memory contents and result, 32 write pulses total.
REQ-033 Header dim=0, then k=33 -> each gives one FSL word 32'hFFFFFFFF with Control=1, no memory writes, start never high.
REQ-034 Control=1 word after 3 point words -> exactly 3 mem_a writes, error word sent, return to IDLE.
REQ-035 FSL_M_Full held 1 for 10 cycles at SEND -> FSL_M_Write 0 throughout, result sent first cycle Full drops.
REQ-036 FSL_Rst low during LOAD_B and during RUN -> all outputs 0 same cycle, next header accepted normally.
